// File: rtl/addsub_sequencer_if.sv
// Operand/opcode request and result bus of the add/sub/mul sequencer.
// The master drives requests; the slave (the sequencer) returns results.
interface addsub_sequencer_if;
    logic        start;
    logic [1:0]  opcode;
    logic [15:0] inputA;
    logic [15:0] inputB;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry;
    logic        overflow;
    logic        err;

    modport master (
        output start, opcode, inputA, inputB,
        input  busy, done, result, carry, overflow, err
    );

    modport slave (
        input  start, opcode, inputA, inputB,
        output busy, done, result, carry, overflow, err
    );
endinterface

// File: rtl/addsub_sequencer.sv
// Multi-cycle ADD/SUB/MUL sequencer sharing one 16-bit ripple add/sub datapath.
// Define ADDSUB_SEQ_MUL_EN to build the 16-iteration unsigned multiply; otherwise MUL is reserved.
module addsub_sequencer (
    input logic               clk,
    input logic               rst_n,
    addsub_sequencer_if.slave bus
);

`ifdef ADDSUB_SEQ_MUL_EN
    typedef enum logic [1:0] {StIdle, StExec, StDone, StMul} state_e;
`else
    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;
`endif

    state_e      state_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        mode_q;
    logic [31:0] acc_q;
    logic        c_stage_q;
    logic        v_stage_q;
    logic        err_stage_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] result_q;
    logic        carry_q;
    logic        overflow_q;
    logic        err_q;
`ifdef ADDSUB_SEQ_MUL_EN
    logic [3:0]  cnt_q;
`endif

    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_mode;
    logic [15:0] b_eff;
    logic [15:0] sum;
    logic        c15;
    logic        c16;

    // Shared adder; carry out of bit 14 is kept separately for signed overflow.
    always_comb begin
        add_a    = a_q;
        add_b    = b_q;
        add_mode = mode_q;
`ifdef ADDSUB_SEQ_MUL_EN
        if (state_q == StMul) begin
            add_a    = acc_q[31:16];
            add_b    = a_q;
            add_mode = 1'b0;
        end
`endif
        b_eff = add_b ^ {16{add_mode}};
        {c15, sum[14:0]} = {1'b0, add_a[14:0]} + {1'b0, b_eff[14:0]} + {15'd0, add_mode};
        {c16, sum[15]}   = {1'b0, add_a[15]} + {1'b0, b_eff[15]} + {1'b0, c15};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            c_stage_q   <= 1'b0;
            v_stage_q   <= 1'b0;
            err_stage_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef ADDSUB_SEQ_MUL_EN
            cnt_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_q         <= bus.inputA;
                        b_q         <= bus.inputB;
                        mode_q      <= bus.opcode[0];
                        busy_q      <= 1'b1;
                        acc_q       <= '0;
                        c_stage_q   <= 1'b0;
                        v_stage_q   <= 1'b0;
                        err_stage_q <= 1'b0;
                        case (bus.opcode)
                            2'b00, 2'b01: state_q <= StExec;
`ifdef ADDSUB_SEQ_MUL_EN
                            2'b10: begin
                                state_q <= StMul;
                                cnt_q   <= '0;
                            end
`endif
                            default: begin
                                err_stage_q <= 1'b1;
                                state_q     <= StDone;
                            end
                        endcase
                    end
                end
                StExec: begin
                    acc_q     <= {16'h0000, sum};
                    c_stage_q <= c16;
                    v_stage_q <= c16 ^ c15;
                    state_q   <= StDone;
                end
`ifdef ADDSUB_SEQ_MUL_EN
                StMul: begin
                    // Shift-and-add: partial sum enters at the top, one product bit retires per cycle.
                    if (b_q[cnt_q]) begin
                        acc_q <= {c16, sum, acc_q[15:1]};
                    end else begin
                        acc_q <= {1'b0, acc_q[31:1]};
                    end
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q <= StDone;
                    end
                end
`endif
                StDone: begin
                    result_q   <= acc_q;
                    carry_q    <= c_stage_q;
                    overflow_q <= v_stage_q;
                    err_q      <= err_stage_q;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = overflow_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Randomized self-checking bench for addsub_sequencer against an arithmetic reference model.
module tb_addsub_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_sequencer_if bus ();

    addsub_sequencer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef ADDSUB_SEQ_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outcome straight from the arithmetic definition of each opcode.
    task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] r, output logic c, output logic v,
                         output logic e, output int lat);
        logic [16:0] w;
        r = '0; c = 1'b0; v = 1'b0; e = 1'b0; lat = 1;
        case (op)
            2'b00: begin
                w   = {1'b0, a} + {1'b0, b};
                r   = {16'h0000, w[15:0]};
                c   = w[16];
                v   = (a[15] == b[15]) && (w[15] != a[15]);
                lat = 2;
            end
            2'b01: begin
                w   = {1'b0, a} - {1'b0, b};
                r   = {16'h0000, w[15:0]};
                c   = (a >= b);
                v   = (a[15] != b[15]) && (w[15] != a[15]);
                lat = 2;
            end
            2'b10: begin
                if (MulEn) begin
                    r   = {16'h0000, a} * {16'h0000, b};
                    lat = 17;
                end else begin
                    e = 1'b1;
                end
            end
            default: e = 1'b1;
        endcase
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input bit pulse_again);
        logic [31:0] er;
        logic        ec, ev, ee;
        int          lat, cyc, extra;
        bit          got;
        model(op, a, b, er, ec, ev, ee, lat);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.inputA = a;
        bus.inputB = b;
        @(posedge clk);
        #1;
        check_eq("busy_accept", {31'd0, bus.busy}, 32'd1);
        // Scramble operands after acceptance; an optional second start lands while busy.
        bus.inputA = 16'($urandom);
        bus.inputB = 16'($urandom);
        if (pulse_again) bus.opcode = 2'($urandom);
        else             bus.start  = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) bus.start = 1'b0;
            if (bus.done) got = 1'b1;
        end
        check_eq("done_seen", {31'd0, got}, 32'd1);
        if (got) begin
            check_eq("latency", cyc, lat);
            check_eq("result", bus.result, er);
            check_eq("carry", {31'd0, bus.carry}, {31'd0, ec});
            check_eq("overflow", {31'd0, bus.overflow}, {31'd0, ev});
            check_eq("err", {31'd0, bus.err}, {31'd0, ee});
            check_eq("busy_at_done", {31'd0, bus.busy}, 32'd0);
        end
        extra = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) extra++;
        end
        check_eq("single_done", extra, 0);
        check_eq("result_hold", bus.result, er);
    endtask

    initial begin
        int nd, last;
        bus.start  = 1'b0;
        bus.opcode = 2'b00;
        bus.inputA = '0;
        bus.inputB = '0;

        #12;
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus.done}, 32'd0);
        check_eq("rst_result", bus.result, 32'd0);
        check_eq("rst_flags", {29'd0, bus.carry, bus.overflow, bus.err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 16'h0004, 16'h0002, 1'b0);
        run_op(2'b01, 16'h8000, 16'h0001, 1'b0);
        run_op(2'b01, 16'h0000, 16'h0001, 1'b0);
        run_op(2'b10, 16'hFFFF, 16'hFFFF, 1'b0);
        run_op(2'b11, 16'h1234, 16'h5678, 1'b0);
        run_op(2'b00, 16'hFFFF, 16'h0001, 1'b1);
        run_op(2'b10, 16'h1234, 16'hABCD, 1'b1);
        run_op(2'b11, 16'h0F0F, 16'hF0F0, 1'b1);

        // Start held high: one ADD every three edges.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = 2'b00;
        bus.inputA = 16'h7FFF;
        bus.inputB = 16'h0001;
        nd   = 0;
        last = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                nd++;
                check_eq("b2b_result", bus.result, 32'h0000_8000);
                check_eq("b2b_overflow", {31'd0, bus.overflow}, 32'd1);
                if (last != 0) check_eq("b2b_gap", c - last, 3);
                last = c;
            end
        end
        bus.start = 1'b0;
        check_eq("b2b_count", nd, 4);
        repeat (4) @(posedge clk);

        // Leave a nonzero result, then abort a MUL with an asynchronous reset.
        run_op(2'b00, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = 2'b10;
        bus.inputA = 16'hFFFF;
        bus.inputB = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("abort_done", {31'd0, bus.done}, 32'd0);
        check_eq("abort_result", bus.result, 32'd0);
        check_eq("abort_flags", {29'd0, bus.carry, bus.overflow, bus.err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        check_eq("abort_no_done", nd, 0);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            run_op(op, 16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
